// File: rtl/timer_text_source_if.sv
// timer_text_source_if: control, pixel-scan and text-output signals of the countdown timer text source
//   master modport: drives start, pause, x, y; observes the text and timer outputs
//   slave modport : the timer itself
interface timer_text_source_if;
    logic       start;
    logic       pause;
    logic [9:0] x;
    logic [9:0] y;
    logic [6:0] ascii_out;
    logic [9:0] x_desired;
    logic [9:0] y_desired;
    logic [7:0] secs_bcd;
    logic       time_up;
    modport master (output start, pause, x, y, input ascii_out, x_desired, y_desired, secs_bcd, time_up);
    modport slave (input start, pause, x, y, output ascii_out, x_desired, y_desired, secs_bcd, time_up);
endinterface

// File: rtl/timer_text_source.sv
// timer_text_source: BCD countdown timer rendered as the text string "TIME nn" for the VGA text window
//   clk       : pixel clock
//   reset     : asynchronous active-low reset
//   bus.start : one-cycle pulse, reload START_SECS and run
//   bus.pause : level, freezes the countdown while high
//   bus.x/y   : scanned pixel position
//   bus.ascii_out, bus.x_desired, bus.y_desired : character and slot corner under the pixel, one cycle later
//   bus.secs_bcd : {tens, ones} seconds remaining
//   bus.time_up  : high while the countdown has expired
// Optional: define TIMER_BLINK_LAST_EN to blink the digits during the last ten seconds and after expiry.
module timer_text_source #(
    parameter int CLK_HZ     = 25000000,
    parameter int START_SECS = 60,
    parameter int TEXT_X     = 560,
    parameter int TEXT_Y     = 16
) (
    input logic clk,
    input logic reset,
    timer_text_source_if.slave bus
);
    localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
    localparam logic [7:0] START_BCD = 8'((START_SECS / 10) * 16 + START_SECS % 10);
    localparam logic [10:0] TX = 11'(TEXT_X);
    localparam logic [10:0] TY = 11'(TEXT_Y);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [7:0]    secs;
    logic          time_up;
    logic          tick;
    logic [7:0]    secs_dec;
    logic [10:0]   xe, ye, dx;
    logic [2:0]    slot;
    logic          in_row;
    logic          blank;
    logic [6:0]    glyph;
    logic [6:0]    ascii_r;
    logic [9:0]    xd_r, yd_r;

    assign tick = state == RUN && presc == LAST;
    assign secs_dec = secs[3:0] != 4'd0 ? {secs[7:4], secs[3:0] - 4'd1} :
                      secs[7:4] != 4'd0 ? {secs[7:4] - 4'd1, 4'd9} : 8'h00;

    // start overrides every state, including a coincident tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            presc   <= '0;
            secs    <= START_BCD;
            time_up <= 1'b0;
        end else if (bus.start) begin
            state   <= RUN;
            presc   <= '0;
            secs    <= START_BCD;
            time_up <= 1'b0;
        end else if (state == RUN) begin
            presc   <= tick ? '0 : presc + 1'b1;
            secs    <= tick ? secs_dec : secs;
            state   <= tick && secs == 8'h01 ? DONE : bus.pause ? HOLD : RUN;
            time_up <= tick && secs == 8'h01;
        end else if (state == HOLD && !bus.pause) begin
            state <= RUN;
        end
    end

`ifdef TIMER_BLINK_LAST_EN
    localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);
    logic [PW-1:0] free;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) free <= '0;
        else free <= free == LAST ? '0 : free + 1'b1;
    end
    // the countdown prescaler is frozen outside RUN/HOLD, so DONE blinks off a free-running copy
    assign blank = ((state == RUN || state == HOLD) && secs <= 8'h10 && presc >= HALF) ||
                   (state == DONE && free >= HALF);
`else
    assign blank = 1'b0;
`endif

    // 11-bit arithmetic so TEXT_X+55 cannot wrap
    assign xe     = {1'b0, bus.x};
    assign ye     = {1'b0, bus.y};
    assign dx     = xe - TX;
    assign slot   = 3'(dx >> 3);
    assign in_row = ye >= TY && ye <= TY + 11'd15 && xe >= TX && xe <= TX + 11'd55;
    assign glyph  = slot == 3'd0 ? 7'h54 :
                    slot == 3'd1 ? 7'h49 :
                    slot == 3'd2 ? 7'h4D :
                    slot == 3'd3 ? 7'h45 :
                    slot == 3'd4 || blank ? 7'h20 :
                    slot == 3'd5 ? {3'b011, secs[7:4]} : {3'b011, secs[3:0]};

    // outside the row the corner is parked at 3FF so no text window can match
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ascii_r <= 7'h20;
            xd_r    <= 10'h3FF;
            yd_r    <= 10'h3FF;
        end else begin
            ascii_r <= in_row ? glyph : 7'h20;
            xd_r    <= in_row ? 10'(TX + {5'b0, slot, 3'b0}) : 10'h3FF;
            yd_r    <= in_row ? 10'(TY) : 10'h3FF;
        end
    end

    assign bus.ascii_out = ascii_r;
    assign bus.x_desired = xd_r;
    assign bus.y_desired = yd_r;
    assign bus.secs_bcd  = secs;
    assign bus.time_up   = time_up;
endmodule

// File: doc/timer_text_source.md
Name: timer_text_source

Overview:
- Game countdown timer that produces the character stream consumed by the text-window generator.
- Keeps seconds remaining as two BCD digits and renders them as the 7-character string "TIME nn".
- For each scanned pixel (x, y), it outputs the ASCII code and the top-left corner of the character slot under that pixel.
- Sits between game control (start/pause, time-up) and the VGA text/font path.

Parameters:
CLK_HZ, 25000000, clk cycles per second tick (bench overrides to a small value)
START_SECS, 60, countdown start value, legal range 1..99
TEXT_X, 560, x pixel of slot 0 left edge
TEXT_Y, 16, y pixel of text row top edge

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous active-low reset (0 = reset)
start  in  1  single-cycle pulse: load START_SECS and run
pause  in  1  level; while high, countdown frozen
x  in  10  current pixel column
y  in  10  current pixel row
ascii_out  out  7  ASCII code for pixel's slot, registered
x_desired  out  10  slot top-left x, registered
y_desired  out  10  slot top-left y, registered
secs_bcd  out  8  {tens, ones} BCD seconds remaining
time_up  out  1  high while in DONE state

Behaviour:
- Reset (reset low, async): state IDLE, secs_bcd = BCD(START_SECS), prescaler = 0, ascii_out = 7'h20, x_desired = 10'h3FF, y_desired = 10'h3FF, time_up = 0.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: pause=1 -> HOLD; tick with secs_bcd==8'h01 -> DONE.
  - HOLD: pause=0 -> RUN.
  - DONE: start -> RUN.
  - start in any state reloads secs_bcd = BCD(START_SECS) and clears the prescaler, then enters RUN. If pause is also high that cycle, state is RUN this cycle and HOLD next cycle.
- Prescaler:
  - Counts 0..CLK_HZ-1 only in RUN.
  - Tick = prescaler==CLK_HZ-1; prescaler wraps to 0 on tick.
  - Holds its value in HOLD, IDLE and DONE. Pausing does not lose partial-second progress.
  - start in the same cycle as a tick: start wins and no decrement occurs.
- BCD decrement on tick:
  - ones!=0: ones-1.
  - ones==0: ones=9, tens-1.
  - Never decrements below 00. DONE entered with secs_bcd = 8'h00; time_up asserts the cycle after the final tick and holds until start.
- Text mapping, 1-cycle latency from x/y to outputs:
  - In-row: y in [TEXT_Y, TEXT_Y+15] and x in [TEXT_X, TEXT_X+55].
  - slot = (x-TEXT_X)>>3, 0..6.
  - x_desired = TEXT_X + 8*slot; y_desired = TEXT_Y.
  - ascii_out by slot: 0 'T'(7'h54), 1 'I'(7'h49), 2 'M'(7'h4D), 3 'E'(7'h45), 4 ' '(7'h20), 5 7'h30+tens, 6 7'h30+ones.
  - Outside the text row: ascii_out = 7'h20, x_desired = y_desired = 10'h3FF, so no window ever matches.
- Digits shown are the secs_bcd value registered in the same cycle as the pixel lookup. No frame-coherence guarantee: a tick mid-frame may tear.
- All 10-bit arithmetic is unsigned, computed in 11 bits internally to avoid wrap at TEXT_X+55.

Optional Feature:
- Macro: TIMER_BLINK_LAST_EN.
- Defined: while in RUN or HOLD with secs_bcd <= 8'h10, slots 5-6 show 7'h20 during the second half of each second (prescaler >= CLK_HZ/2). In DONE, digits "00" blink at the same rate using a free-running copy of the prescaler.
- Undefined: digits always displayed; no extra prescaler logic.

Test Plan:
- Setup: CLK_HZ=10, START_SECS=12.
- Reset then start pulse -> secs_bcd 8'h12 immediately; 8'h11 after 10 cycles; 8'h10 after 20; 8'h09 after 30 (tens borrow).
- Run to end -> secs_bcd 8'h00 after 120 cycles; time_up=1 next cycle; stays 1 with no further decrement for 50 cycles.
- pause high for 25 cycles at prescaler=4 -> secs_bcd and prescaler frozen; decrement resumes 6 cycles after pause falls.
- Scan x=560..615, y=16 with secs=8'h47 -> one cycle later ascii_out = T,I,M,E,' ',7'h34,7'h37, each held 8 pixels; x_desired steps 560,568,...,608; y_desired=16.
- x=559 or y=32 -> ascii_out 7'h20, x_desired/y_desired 10'h3FF.
- Assert reset low mid-count (secs 8'h07) asynchronously -> outputs take reset values without a clk edge; start then runs again from 8'h12.
